// File: rtl/oled_spi_ctrl.sv
// SSD1306-class SPI OLED controller: power-up reset, init list, framebuffer streaming,
// runtime command injection and single-shot or continuous refresh.
module oled_spi_ctrl #(
    parameter int STARTUP_WAIT = 10000000,
    parameter int CLK_DIV      = 1,
    parameter int COLUMNS      = 128,
    parameter int PAGES        = 8,
    parameter int ADDR_W       = $clog2(COLUMNS*PAGES)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              io_sclk,
    output logic              io_sdin,
    output logic              io_cs,
    output logic              io_dc,
    output logic              io_reset,
    output logic [ADDR_W-1:0] pixel_addr,
    input  logic [7:0]        pixel_data,
    input  logic              frame_start,
    input  logic              continuous,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd_byte,
    output logic              cmd_ready,
    output logic              init_done,
    output logic              busy,
    output logic              frame_done
);
    localparam int CW = $clog2(STARTUP_WAIT + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLUMNS*PAGES - 1);

    typedef enum logic [2:0] {
        S_PWR, S_INIT_LOAD, S_WIN_LOAD, S_PIX_LOAD, S_CMD_LOAD, S_SEND, S_GAP, S_IDLE
    } state_t;
    typedef enum logic [1:0] {K_INIT, K_WIN, K_PIX, K_CMD} kind_t;

    state_t            r_state, w_state;
    kind_t             r_kind, w_kind;
    logic [CW-1:0]     r_pcnt, w_pcnt;
    logic [1:0]        r_phase, w_phase;
    logic [DW-1:0]     r_div, w_div;
    logic [2:0]        r_bit, w_bit;
    logic [7:0]        r_sh, w_sh, r_cmd, w_cmd, w_load_byte;
    logic [4:0]        r_idx, w_idx;
    logic              w_sclk, w_sdin, w_cs, w_dc, w_reset;
    logic              w_init_done, w_busy, w_ready, w_frame_done;
    logic [ADDR_W-1:0] w_addr;

    function automatic logic [7:0] f_init(input logic [4:0] i);
        case (i)
            5'd0:  f_init = 8'hAE;  5'd1:  f_init = 8'h81;  5'd2:  f_init = 8'h7F;
            5'd3:  f_init = 8'hA6;  5'd4:  f_init = 8'h20;  5'd5:  f_init = 8'h00;
            5'd6:  f_init = 8'hC8;  5'd7:  f_init = 8'h40;  5'd8:  f_init = 8'hA1;
            5'd9:  f_init = 8'hA8;  5'd10: f_init = 8'(PAGES*8 - 1);
            5'd11: f_init = 8'hD3;  5'd12: f_init = 8'h00;  5'd13: f_init = 8'hD5;
            5'd14: f_init = 8'h80;  5'd15: f_init = 8'hD9;  5'd16: f_init = 8'h22;
            5'd17: f_init = 8'hDA;  5'd18: f_init = (PAGES == 4) ? 8'h02 : 8'h12;
            5'd19: f_init = 8'hDB;  5'd20: f_init = 8'h20;  5'd21: f_init = 8'h8D;
            5'd22: f_init = 8'h14;  5'd23: f_init = 8'hA4;
            default: f_init = 8'hAF;
        endcase
    endfunction

    function automatic logic [7:0] f_win(input logic [4:0] i);
        case (i)
            5'd0: f_win = 8'h21;  5'd1: f_win = 8'h00;  5'd2: f_win = 8'(COLUMNS - 1);
            5'd3: f_win = 8'h22;  5'd4: f_win = 8'h00;
            default: f_win = 8'(PAGES - 1);
        endcase
    endfunction

    always_comb begin
        case (r_state)
            S_INIT_LOAD: w_load_byte = f_init(r_idx);
            S_WIN_LOAD:  w_load_byte = f_win(r_idx);
            S_PIX_LOAD:  w_load_byte = pixel_data;
            default:     w_load_byte = r_cmd;
        endcase
    end

    always_comb begin
        w_state = r_state;  w_kind = r_kind;  w_pcnt = r_pcnt;  w_phase = r_phase;
        w_div = r_div;  w_bit = r_bit;  w_sh = r_sh;  w_cmd = r_cmd;  w_idx = r_idx;
        w_sclk = io_sclk;  w_sdin = io_sdin;  w_cs = io_cs;  w_dc = io_dc;
        w_reset = io_reset;  w_addr = pixel_addr;  w_init_done = init_done;
        w_frame_done = 1'b0;
        case (r_state)
            S_PWR: begin
                if (r_pcnt == CW'(STARTUP_WAIT - 1)) begin
                    w_pcnt  = '0;
                    w_phase = r_phase + 2'd1;
                    if (r_phase == 2'd0)      w_reset = 1'b0;
                    else if (r_phase == 2'd1) w_reset = 1'b1;
                    else begin
                        w_state = S_INIT_LOAD;  w_idx = '0;  w_dc = 1'b0;
                    end
                end else begin
                    w_pcnt = r_pcnt + 1'b1;
                end
            end
            S_INIT_LOAD, S_WIN_LOAD, S_PIX_LOAD, S_CMD_LOAD: begin
                w_state = S_SEND;  w_cs = 1'b0;  w_sclk = 1'b0;  w_div = '0;  w_bit = 3'd7;
                w_sh = w_load_byte;  w_sdin = w_load_byte[7];
                case (r_state)
                    S_INIT_LOAD: w_kind = K_INIT;
                    S_WIN_LOAD:  w_kind = K_WIN;
                    S_PIX_LOAD:  w_kind = K_PIX;
                    default:     w_kind = K_CMD;
                endcase
            end
            S_SEND: begin
                if (r_div == DW'(CLK_DIV - 1)) begin
                    w_div = '0;
                    if (!io_sclk) begin
                        w_sclk = 1'b1;
                    end else if (r_bit == 3'd0) begin
                        w_cs = 1'b1;  w_state = S_GAP;
                        // Address the next pixel now so RAM data is ready by the next LOAD.
                        if (r_kind == K_PIX)
                            w_addr = (pixel_addr == LAST_ADDR) ? '0 : pixel_addr + 1'b1;
                    end else begin
                        w_bit = r_bit - 3'd1;  w_sclk = 1'b0;
                        w_sh = {r_sh[6:0], 1'b0};  w_sdin = r_sh[6];
                    end
                end else begin
                    w_div = r_div + 1'b1;
                end
            end
            S_GAP: begin
                if (r_div == DW'(CLK_DIV - 1)) begin
                    w_div = '0;
                    case (r_kind)
                        K_INIT: begin
                            if (r_idx == 5'd24) begin
                                w_init_done = 1'b1;
                                if (continuous) begin
                                    w_state = S_WIN_LOAD;  w_idx = '0;  w_dc = 1'b0;
                                end else begin
                                    w_state = S_IDLE;
                                end
                            end else begin
                                w_idx = r_idx + 5'd1;  w_state = S_INIT_LOAD;
                            end
                        end
                        K_WIN: begin
                            if (r_idx == 5'd5) begin
                                w_state = S_PIX_LOAD;  w_dc = 1'b1;
                            end else begin
                                w_idx = r_idx + 5'd1;  w_state = S_WIN_LOAD;
                            end
                        end
                        K_PIX: begin
                            // Address already wrapped to 0 means the last byte just went out.
                            if (pixel_addr == '0) begin
                                w_frame_done = 1'b1;
                                if (continuous) begin
                                    w_state = S_WIN_LOAD;  w_idx = '0;  w_dc = 1'b0;
                                end else begin
                                    w_state = S_IDLE;
                                end
                            end else begin
                                w_state = S_PIX_LOAD;
                            end
                        end
                        default: w_state = S_IDLE;
                    endcase
                end else begin
                    w_div = r_div + 1'b1;
                end
            end
            default: begin
                if (cmd_valid) begin
                    w_cmd = cmd_byte;  w_state = S_CMD_LOAD;  w_dc = 1'b0;
                end else if (frame_start) begin
                    w_state = S_WIN_LOAD;  w_idx = '0;  w_dc = 1'b0;
                end
            end
        endcase
        w_busy  = (w_state != S_IDLE);
        w_ready = (w_state == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_PWR;  r_kind <= K_INIT;  r_pcnt <= '0;  r_phase <= '0;
            r_div <= '0;  r_bit <= '0;  r_sh <= '0;  r_cmd <= '0;  r_idx <= '0;
            io_sclk <= 1'b1;  io_sdin <= 1'b0;  io_cs <= 1'b1;  io_dc <= 1'b1;
            io_reset <= 1'b1;  pixel_addr <= '0;  cmd_ready <= 1'b0;
            init_done <= 1'b0;  busy <= 1'b1;  frame_done <= 1'b0;
        end else begin
            r_state <= w_state;  r_kind <= w_kind;  r_pcnt <= w_pcnt;  r_phase <= w_phase;
            r_div <= w_div;  r_bit <= w_bit;  r_sh <= w_sh;  r_cmd <= w_cmd;  r_idx <= w_idx;
            io_sclk <= w_sclk;  io_sdin <= w_sdin;  io_cs <= w_cs;  io_dc <= w_dc;
            io_reset <= w_reset;  pixel_addr <= w_addr;  cmd_ready <= w_ready;
            init_done <= w_init_done;  busy <= w_busy;  frame_done <= w_frame_done;
        end
    end
endmodule

// File: tb/tb_oled_spi_ctrl.sv
// Bench for oled_spi_ctrl: two instances (128x64 div 1, 128x32 div 2) decoded by an SPI
// byte monitor and checked against an expected byte queue built from the panel protocol.
module tb_oled_spi_ctrl;
    localparam int SW = 4;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] sclk, sdin, cs, dc, prst, idn, bsy, rdy, fdn;
    logic [9:0] addr0;
    logic [8:0] addr1;
    logic [7:0] pd0, pd1, cb;
    logic       fs, cont, cv;

    oled_spi_ctrl #(.STARTUP_WAIT(SW), .CLK_DIV(1), .COLUMNS(128), .PAGES(8)) u0 (
        .clk(clk), .rst(rst), .io_sclk(sclk[0]), .io_sdin(sdin[0]), .io_cs(cs[0]),
        .io_dc(dc[0]), .io_reset(prst[0]), .pixel_addr(addr0), .pixel_data(pd0),
        .frame_start(fs), .continuous(cont), .cmd_valid(cv), .cmd_byte(cb),
        .cmd_ready(rdy[0]), .init_done(idn[0]), .busy(bsy[0]), .frame_done(fdn[0]));

    oled_spi_ctrl #(.STARTUP_WAIT(SW), .CLK_DIV(2), .COLUMNS(128), .PAGES(4)) u1 (
        .clk(clk), .rst(rst), .io_sclk(sclk[1]), .io_sdin(sdin[1]), .io_cs(cs[1]),
        .io_dc(dc[1]), .io_reset(prst[1]), .pixel_addr(addr1), .pixel_data(pd1),
        .frame_start(1'b0), .continuous(1'b0), .cmd_valid(1'b0), .cmd_byte(8'h00),
        .cmd_ready(rdy[1]), .init_done(idn[1]), .busy(bsy[1]), .frame_done(fdn[1]));

    // Framebuffer RAM: each byte holds the low 8 bits of its own address.
    always @(posedge clk) begin
        pd0 <= addr0[7:0];
        pd1 <= addr1[7:0];
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int vectors = 0, miscompares = 0;
    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // ---------------- model ----------------
    logic [8:0] expq0[$], expq1[$];
    int         first_cs[2], init_rise[2], fd_cnt[2], bcnt[2], mnb[2];
    int         fd_t[$];
    logic [7:0] blog[2][32];
    logic [7:0] msh[2];
    logic [1:0] psclk, pcs, pdc, pidn, pfd;

    function automatic logic [7:0] init_b(input int i, input int pages);
        logic [7:0] l [25];
        l = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hC8, 8'h40, 8'hA1, 8'hA8,
              8'(pages*8 - 1), 8'hD3, 8'h00, 8'hD5, 8'h80, 8'hD9, 8'h22, 8'hDA,
              (pages == 4) ? 8'h02 : 8'h12, 8'hDB, 8'h20, 8'h8D, 8'h14, 8'hA4, 8'hAF};
        return l[i];
    endfunction

    task automatic push_exp(input int d, input logic [8:0] v);
        if (d == 0) expq0.push_back(v);
        else        expq1.push_back(v);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? expq0.size() : expq1.size();
    endfunction

    task automatic push_init(input int d, input int pages);
        for (int i = 0; i < 25; i++) push_exp(d, {1'b0, init_b(i, pages)});
    endtask

    task automatic push_frame();
        logic [7:0] w [6];
        w = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
        for (int i = 0; i < 6; i++) push_exp(0, {1'b0, w[i]});
        for (int a = 0; a < 1024; a++) push_exp(0, {1'b1, 8'(a)});
    endtask

    task automatic clear_model();
        expq0.delete();  expq1.delete();  fd_t.delete();
        for (int d = 0; d < 2; d++) begin
            first_cs[d] = -1;  init_rise[d] = -1;  fd_cnt[d] = 0;  bcnt[d] = 0;  mnb[d] = 0;
        end
    endtask

    // ---------------- compare process ----------------
    initial forever begin
        logic [8:0] e;
        @(negedge clk);
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (!cs[d]) begin
                    if (pcs[d] && first_cs[d] < 0) first_cs[d] = cyc;
                    if (!pcs[d]) chk($sformatf("dut%0d dc_stable_while_cs_low", d), dc[d], pdc[d]);
                    if (sclk[d] && !psclk[d]) begin
                        msh[d] = {msh[d][6:0], sdin[d]};
                        mnb[d]++;
                        if (mnb[d] == 8) begin
                            mnb[d] = 0;
                            if (bcnt[d] < 32) blog[d][bcnt[d]] = msh[d];
                            if (qsize(d) == 0) begin
                                chk($sformatf("dut%0d unexpected_byte%0d", d, bcnt[d]),
                                    {dc[d], msh[d]}, -1);
                            end else begin
                                e = (d == 0) ? expq0.pop_front() : expq1.pop_front();
                                chk($sformatf("dut%0d byte%0d {dc,data}", d, bcnt[d]),
                                    {dc[d], msh[d]}, e);
                            end
                            bcnt[d]++;
                        end
                    end
                end else begin
                    mnb[d] = 0;
                end
                if (idn[d] && !pidn[d] && init_rise[d] < 0) init_rise[d] = cyc;
                if (fdn[d]) begin
                    fd_cnt[d]++;
                    if (d == 0) fd_t.push_back(cyc);
                    chk($sformatf("dut%0d frame_done_one_cycle", d), pfd[d], 0);
                end
                chk($sformatf("dut%0d cmd_ready_is_idle", d), rdy[d], !bsy[d]);
            end
        end
        psclk = sclk;  pcs = cs;  pdc = dc;  pidn = idn;  pfd = fdn;
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0, b0, nfd, nlow;
        logic [11:0] pat;
        pat = 12'b1111_0000_1111;
        fs = 1'b0;  cont = 1'b0;  cv = 1'b0;  cb = 8'h00;
        clear_model();

        @(negedge clk);
        rst = 1'b1;
        push_init(0, 8);  push_init(1, 4);
        @(negedge clk);
        chk("rst io_sclk", sclk[0], 1);      chk("rst io_sdin", sdin[0], 0);
        chk("rst io_cs", cs[0], 1);          chk("rst io_dc", dc[0], 1);
        chk("rst io_reset", prst[0], 1);     chk("rst pixel_addr", addr0, 0);
        chk("rst cmd_ready", rdy[0], 0);     chk("rst init_done", idn[0], 0);
        chk("rst busy", bsy[0], 1);          chk("rst frame_done", fdn[0], 0);
        @(negedge clk);
        rst = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("dut0 io_reset[%0d]", k), prst[0], pat[11-k]);
            chk($sformatf("dut1 io_reset[%0d]", k), prst[1], pat[11-k]);
        end
        for (int k = 0; k < 2000 && idn != 2'b11; k++) @(negedge clk);
        @(negedge clk);
        chk("init_done timeout", idn, 2'b11);
        chk("dut0 first cs fall", first_cs[0] - t0, 13);
        chk("dut1 first cs fall", first_cs[1] - t0, 13);
        chk("dut0 init_done rise", init_rise[0] - t0, 462);
        chk("dut1 init_done rise", init_rise[1] - t0, 887);
        chk("dut0 first byte", blog[0][0], 8'hAE);
        chk("dut1 init byte11", blog[1][10], 8'h1F);
        chk("dut1 init byte19", blog[1][18], 8'h02);
        chk("dut1 init bytes left", qsize(1), 0);

        // single frame
        chk("idle busy", bsy[0], 0);
        chk("idle cmd_ready", rdy[0], 1);
        push_frame();
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        for (int k = 0; k < 20000 && fd_cnt[0] < 1; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("frame1 frame_done count", fd_cnt[0], 1);
        chk("frame1 pixel_addr wrap", addr0, 0);
        chk("frame1 busy after", bsy[0], 0);
        chk("frame1 bytes left", qsize(0), 0);

        // commands with simultaneous frame_start
        b0 = bcnt[0];
        push_exp(0, {1'b0, 8'h81});
        cv = 1'b1;  cb = 8'h81;  fs = 1'b1;
        @(negedge clk);
        cv = 1'b0;  fs = 1'b0;
        chk("cmd81 busy", bsy[0], 1);
        for (int k = 0; k < 100 && !rdy[0]; k++) @(negedge clk);
        push_exp(0, {1'b0, 8'h40});
        cv = 1'b1;  cb = 8'h40;  fs = 1'b1;
        @(negedge clk);
        cv = 1'b0;  fs = 1'b0;
        for (int k = 0; k < 100 && !rdy[0]; k++) @(negedge clk);
        repeat (50) @(negedge clk);
        chk("cmd bytes sent", bcnt[0] - b0, 2);
        chk("cmd no frame", fd_cnt[0], 1);
        chk("cmd idle", bsy[0], 0);

        // continuous: two frames, continuous dropped during the second
        push_frame();  push_frame();
        cont = 1'b1;  fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        nfd = 0;  nlow = 0;
        for (int k = 0; k < 40000 && nfd < 2; k++) begin
            @(negedge clk);
            if (fdn[0]) nfd++;
            else if (!bsy[0]) nlow++;
            if (nfd >= 1) cont = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("cont frame_done count", fd_t.size(), 3);
        if (fd_t.size() >= 3) chk("cont frame spacing", fd_t[2] - fd_t[1], 18540);
        chk("cont busy low cycles", nlow, 0);
        chk("cont idle after", bsy[0], 0);
        chk("cont bytes left", qsize(0), 0);

        // reset in the middle of data byte 500
        push_frame();
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        b0 = bcnt[0];
        for (int k = 0; k < 12000 && bcnt[0] - b0 < 506; k++) @(negedge clk);
        for (int k = 0; k < 40 && !(cs[0] == 1'b0 && sclk[0] == 1'b0); k++) @(negedge clk);
        chk("abort reached byte500", bcnt[0] - b0, 506);
        rst = 1'b1;
        clear_model();
        push_init(0, 8);  push_init(1, 4);
        @(negedge clk);
        chk("abort io_cs", cs[0], 1);       chk("abort io_sclk", sclk[0], 1);
        chk("abort io_reset", prst[0], 1);  chk("abort init_done", idn[0], 0);
        chk("abort busy", bsy[0], 1);
        rst = 1'b0;
        t0 = cyc;
        chk("abort pwr io_reset low", prst[0], 1);
        repeat (4) @(negedge clk);
        chk("abort pwr io_reset low phase", prst[0], 0);
        for (int k = 0; k < 2000 && idn != 2'b11; k++) @(negedge clk);
        @(negedge clk);
        chk("re-init timeout", idn, 2'b11);
        chk("re-init first cs fall", first_cs[0] - t0, 13);
        chk("re-init init_done rise", init_rise[0] - t0, 462);
        chk("re-init dut0 bytes left", qsize(0), 0);
        chk("re-init dut1 bytes left", qsize(1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
